// File: rtl/aurora_link_pkg.sv
// Shared encodings and widths for the Aurora link monitor.
package aurora_link_pkg;

   localparam int STATE_W = 3;
   localparam int TIMER_W = 20;
   localparam int RETRY_W = 4;
   localparam int SOFT_W  = 16;

   typedef enum logic [STATE_W-1:0] {
      ST_WAIT_UP   = 3'd0,
      ST_STABLE    = 3'd1,
      ST_LINK_OK   = 3'd2,
      ST_RST_PULSE = 3'd3,
      ST_HOLDOFF   = 3'd4,
      ST_FAIL      = 3'd5
   } state_t;

   localparam logic [SOFT_W-1:0] SOFT_MAX = '1;

endpackage

// File: rtl/link_timer.sv
// Shared state timer: clears to zero, otherwise counts up while enabled.
module link_timer #(
   parameter int W = 20
) (
   input  logic         aurora_log_clk,
   input  logic         aurora_rst,
   input  logic         clear,
   input  logic         enable,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge aurora_log_clk) begin
      if (aurora_rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/aurora_link_monitor.sv
// Aurora link bring-up monitor: waits for lanes, qualifies stability and
// issues bounded reset retries to the core.
//
//  state        | meaning
//  -------------+----------------------------------------------
//  WAIT_UP      | waiting for channel_up and lane_up
//  STABLE       | both ups seen, qualifying for STABLE_CYCLES
//  LINK_OK      | link usable, soft errors counted
//  RST_PULSE    | reset_pb asserted for RST_PULSE_CYCLES
//  HOLDOFF      | post-reset quiet time, link inputs ignored
//  FAIL         | retries exhausted, waiting for retry_clr
module aurora_link_monitor
   import aurora_link_pkg::*;
#(
   parameter int UP_TIMEOUT       = 1000000,
   parameter int STABLE_CYCLES    = 10000,
   parameter int RST_PULSE_CYCLES = 128,
   parameter int HOLDOFF_CYCLES   = 50000,
   parameter int MAX_RETRY        = 8
) (
   input  logic                  aurora_log_clk,
   input  logic                  aurora_rst,
   input  logic                  channel_up,
   input  logic                  lane_up,
   input  logic                  hard_err,
   input  logic                  soft_err,
   input  logic                  retry_clr,
   output logic                  link_ready,
   output logic                  reset_pb,
   output logic                  link_fail,
   output logic [RETRY_W-1:0]    retry_cnt,
   output logic [SOFT_W-1:0]     soft_err_cnt,
   output logic [STATE_W-1:0]    state_o
);

   localparam logic [TIMER_W-1:0] UP_TC     = TIMER_W'(UP_TIMEOUT - 1);
   localparam logic [TIMER_W-1:0] STABLE_TC = TIMER_W'(STABLE_CYCLES - 1);
   localparam logic [TIMER_W-1:0] PULSE_TC  = TIMER_W'(RST_PULSE_CYCLES - 1);
   localparam logic [TIMER_W-1:0] HOLD_TC   = TIMER_W'(HOLDOFF_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);

   state_t               state_q, state_d;
   logic [RETRY_W-1:0]   retry_q, retry_d, retry_base;
   logic [SOFT_W-1:0]    soft_q, soft_d, soft_base;
   logic                 link_ready_q, link_ready_d;
   logic                 reset_pb_q, reset_pb_d;
   logic                 link_fail_q, link_fail_d;
   logic [TIMER_W-1:0]   timer;
   logic                 timer_clr;
   logic                 ups;
   logic                 go_rst;

   assign ups = channel_up & lane_up;

   link_timer #(.W(TIMER_W)) u_timer (
      .aurora_log_clk (aurora_log_clk),
      .aurora_rst     (aurora_rst),
      .clear          (timer_clr),
      .enable         (timer != '1),
      .count          (timer)
   );

   always_comb begin
      state_d    = state_q;
      go_rst     = 1'b0;
      retry_base = retry_clr ? '0 : retry_q;
      retry_d    = retry_base;

      case (state_q)
         ST_WAIT_UP: begin
            if (ups) begin
               state_d = ST_STABLE;
            end else if (timer == UP_TC) begin
               go_rst = 1'b1;
            end
         end
         ST_STABLE: begin
            if (hard_err) begin
               go_rst = 1'b1;
            end else if (!ups) begin
               state_d = ST_WAIT_UP;
            end else if (timer == STABLE_TC) begin
               state_d = ST_LINK_OK;
            end
         end
         ST_LINK_OK: begin
            if (hard_err || !ups) begin
               go_rst = 1'b1;
            end
         end
         ST_RST_PULSE: begin
            if (timer == PULSE_TC) begin
               state_d = ST_HOLDOFF;
            end
         end
         ST_HOLDOFF: begin
            if (timer == HOLD_TC) begin
               state_d = ST_WAIT_UP;
            end
         end
         ST_FAIL: begin
            go_rst = retry_clr;
         end
         default: begin
            state_d = ST_WAIT_UP;
         end
      endcase

      // Every route into RST_PULSE is gated by the retry budget.
      if (go_rst) begin
         if (retry_base == RETRY_LIM) begin
            state_d = ST_FAIL;
         end else begin
            state_d = ST_RST_PULSE;
            retry_d = retry_base + 1'b1;
         end
      end

      if (state_d == ST_LINK_OK && state_q != ST_LINK_OK) begin
         retry_d = '0;
      end

      timer_clr = (state_d != state_q);

      // A cycle that carries hard_err is a fault cycle, not a soft-error cycle.
      soft_base = retry_clr ? '0 : soft_q;
      soft_d    = soft_base;
      if (state_q == ST_LINK_OK && soft_err && !hard_err && soft_base != SOFT_MAX) begin
         soft_d = soft_base + 1'b1;
      end

      link_ready_d = (state_d == ST_LINK_OK);
      reset_pb_d   = (state_d == ST_RST_PULSE);
      link_fail_d  = (state_d == ST_FAIL);
   end

   always_ff @(posedge aurora_log_clk) begin
      if (aurora_rst) begin
         state_q      <= ST_WAIT_UP;
         retry_q      <= '0;
         soft_q       <= '0;
         link_ready_q <= 1'b0;
         reset_pb_q   <= 1'b0;
         link_fail_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         retry_q      <= retry_d;
         soft_q       <= soft_d;
         link_ready_q <= link_ready_d;
         reset_pb_q   <= reset_pb_d;
         link_fail_q  <= link_fail_d;
      end
   end

   assign link_ready   = link_ready_q;
   assign reset_pb     = reset_pb_q;
   assign link_fail    = link_fail_q;
   assign retry_cnt    = retry_q;
   assign soft_err_cnt = soft_q;
   assign state_o      = state_q;

endmodule

// File: tb/tb_aurora_link_monitor.sv
// Scoreboard bench for aurora_link_monitor with shortened timing parameters.
module tb_aurora_link_monitor;

   localparam int UP_T   = 100;
   localparam int STAB_C = 20;
   localparam int PULS_C = 8;
   localparam int HOLD_C = 16;
   localparam int MAXR   = 3;

   logic        clk = 1'b0;
   logic        aurora_rst;
   logic        channel_up, lane_up, hard_err, soft_err, retry_clr;
   logic        link_ready, reset_pb, link_fail;
   logic [3:0]  retry_cnt;
   logic [15:0] soft_err_cnt;
   logic [2:0]  state_o;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   aurora_link_monitor #(
      .UP_TIMEOUT       (UP_T),
      .STABLE_CYCLES    (STAB_C),
      .RST_PULSE_CYCLES (PULS_C),
      .HOLDOFF_CYCLES   (HOLD_C),
      .MAX_RETRY        (MAXR)
   ) dut (
      .aurora_log_clk (clk),
      .aurora_rst     (aurora_rst),
      .channel_up     (channel_up),
      .lane_up        (lane_up),
      .hard_err       (hard_err),
      .soft_err       (soft_err),
      .retry_clr      (retry_clr),
      .link_ready     (link_ready),
      .reset_pb       (reset_pb),
      .link_fail      (link_fail),
      .retry_cnt      (retry_cnt),
      .soft_err_cnt   (soft_err_cnt),
      .state_o        (state_o)
   );

   task automatic do_reset();
      @(negedge clk);
      aurora_rst = 1'b1;
      channel_up = 1'b0; lane_up = 1'b0; hard_err = 1'b0; soft_err = 1'b0; retry_clr = 1'b0;
      repeat (3) @(negedge clk);
      aurora_rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      aurora_rst = 1'b1;
      channel_up = 1'b1; lane_up = 1'b1; hard_err = 1'b0; soft_err = 1'b1; retry_clr = 1'b0;
      sb.push_back('{"rst_state", 32'd0});
      sb.push_back('{"rst_link_ready", 32'd0});
      sb.push_back('{"rst_reset_pb", 32'd0});
      sb.push_back('{"rst_link_fail", 32'd0});
      sb.push_back('{"rst_retry", 32'd0});
      sb.push_back('{"rst_soft", 32'd0});
      repeat (3) @(negedge clk);
      e = sb.pop_front(); total++;
      if (32'(state_o) !== e.exp) begin bad++; $display("FAIL %s: got %0h want %0h", e.name, state_o, e.exp); end
      e = sb.pop_front(); total++;
      if (32'(link_ready) !== e.exp) begin bad++; $display("FAIL %s: got %0h want %0h", e.name, link_ready, e.exp); end
      e = sb.pop_front(); total++;
      if (32'(reset_pb) !== e.exp) begin bad++; $display("FAIL %s: got %0h want %0h", e.name, reset_pb, e.exp); end
      e = sb.pop_front(); total++;
      if (32'(link_fail) !== e.exp) begin bad++; $display("FAIL %s: got %0h want %0h", e.name, link_fail, e.exp); end
      e = sb.pop_front(); total++;
      if (32'(retry_cnt) !== e.exp) begin bad++; $display("FAIL %s: got %0h want %0h", e.name, retry_cnt, e.exp); end
      e = sb.pop_front(); total++;
      if (32'(soft_err_cnt) !== e.exp) begin bad++; $display("FAIL %s: got %0h want %0h", e.name, soft_err_cnt, e.exp); end
   endtask

   task automatic test_link_up();
      int ks, kr;
      do_reset();
      repeat (5) @(negedge clk);
      channel_up = 1'b1; lane_up = 1'b1;
      sb.push_back('{"stable_entry_cycle", 32'd6});
      sb.push_back('{"ready_delay", 32'(STAB_C)});
      sb.push_back('{"up_retry", 32'd0});
      ks = -1; kr = -1;
      for (int i = 6; i <= 80; i++) begin
         @(negedge clk);
         if (ks < 0 && state_o == 3'd1) ks = i;
         if (link_ready === 1'b1) begin kr = i; break; end
      end
      e = sb.pop_front(); total++;
      if (32'(ks) !== e.exp) begin bad++; $display("FAIL %s: got %0d want %0d", e.name, ks, e.exp); end
      e = sb.pop_front(); total++;
      if (32'(kr - ks) !== e.exp) begin bad++; $display("FAIL %s: got %0d want %0d", e.name, kr - ks, e.exp); end
      e = sb.pop_front(); total++;
      if (32'(retry_cnt) !== e.exp) begin bad++; $display("FAIL %s: got %0h want %0h", e.name, retry_cnt, e.exp); end
   endtask

   task automatic test_timeout();
      int k, w;
      do_reset();
      sb.push_back('{"pulse_start", 32'(UP_T)});
      sb.push_back('{"timeout_retry", 32'd1});
      sb.push_back('{"pulse_width", 32'(PULS_C)});
      sb.push_back('{"holdoff_state", 32'd4});
      sb.push_back('{"holdoff_last", 32'd4});
      sb.push_back('{"back_to_wait", 32'd0});
      k = 0;
      while (k < 300) begin
         @(negedge clk); k++;
         if (reset_pb === 1'b1) break;
      end
      e = sb.pop_front(); total++;
      if (32'(k) !== e.exp) begin bad++; $display("FAIL %s: got %0d want %0d", e.name, k, e.exp); end
      e = sb.pop_front(); total++;
      if (32'(retry_cnt) !== e.exp) begin bad++; $display("FAIL %s: got %0h want %0h", e.name, retry_cnt, e.exp); end
      w = 0;
      while (reset_pb === 1'b1 && w < 50) begin w++; @(negedge clk); end
      e = sb.pop_front(); total++;
      if (32'(w) !== e.exp) begin bad++; $display("FAIL %s: got %0d want %0d", e.name, w, e.exp); end
      e = sb.pop_front(); total++;
      if (32'(state_o) !== e.exp) begin bad++; $display("FAIL %s: got %0h want %0h", e.name, state_o, e.exp); end
      repeat (HOLD_C - 1) @(negedge clk);
      e = sb.pop_front(); total++;
      if (32'(state_o) !== e.exp) begin bad++; $display("FAIL %s: got %0h want %0h", e.name, state_o, e.exp); end
      @(negedge clk);
      e = sb.pop_front(); total++;
      if (32'(state_o) !== e.exp) begin bad++; $display("FAIL %s: got %0h want %0h", e.name, state_o, e.exp); end
   endtask

   task automatic test_fail();
      int c, w;
      do_reset();
      for (int p = 0; p < MAXR; p++) begin
         sb.push_back('{"retry_during_pulse", 32'(p + 1)});
         sb.push_back('{"retry_pulse_width", 32'(PULS_C)});
         c = 0;
         while (reset_pb !== 1'b1 && c < 300) begin @(negedge clk); c++; end
         e = sb.pop_front(); total++;
         if (32'(retry_cnt) !== e.exp) begin bad++; $display("FAIL %s: got %0h want %0h", e.name, retry_cnt, e.exp); end
         w = 0;
         while (reset_pb === 1'b1 && w < 50) begin w++; @(negedge clk); end
         e = sb.pop_front(); total++;
         if (32'(w) !== e.exp) begin bad++; $display("FAIL %s: got %0d want %0d", e.name, w, e.exp); end
      end
      sb.push_back('{"fail_delay", 32'(HOLD_C + UP_T)});
      sb.push_back('{"fail_state", 32'd5});
      sb.push_back('{"fail_reset_pb", 32'd0});
      sb.push_back('{"fail_retry", 32'(MAXR)});
      sb.push_back('{"fail_sticky", 32'd5});
      c = 0;
      while (link_fail !== 1'b1 && c < 300) begin @(negedge clk); c++; end
      e = sb.pop_front(); total++;
      if (32'(c) !== e.exp) begin bad++; $display("FAIL %s: got %0d want %0d", e.name, c, e.exp); end
      e = sb.pop_front(); total++;
      if (32'(state_o) !== e.exp) begin bad++; $display("FAIL %s: got %0h want %0h", e.name, state_o, e.exp); end
      e = sb.pop_front(); total++;
      if (32'(reset_pb) !== e.exp) begin bad++; $display("FAIL %s: got %0h want %0h", e.name, reset_pb, e.exp); end
      e = sb.pop_front(); total++;
      if (32'(retry_cnt) !== e.exp) begin bad++; $display("FAIL %s: got %0h want %0h", e.name, retry_cnt, e.exp); end
      repeat (10) @(negedge clk);
      e = sb.pop_front(); total++;
      if (32'(state_o) !== e.exp) begin bad++; $display("FAIL %s: got %0h want %0h", e.name, state_o, e.exp); end
      retry_clr = 1'b1;
      sb.push_back('{"clr_state", 32'd3});
      sb.push_back('{"clr_reset_pb", 32'd1});
      sb.push_back('{"clr_retry", 32'd1});
      sb.push_back('{"clr_link_fail", 32'd0});
      @(negedge clk);
      retry_clr = 1'b0;
      e = sb.pop_front(); total++;
      if (32'(state_o) !== e.exp) begin bad++; $display("FAIL %s: got %0h want %0h", e.name, state_o, e.exp); end
      e = sb.pop_front(); total++;
      if (32'(reset_pb) !== e.exp) begin bad++; $display("FAIL %s: got %0h want %0h", e.name, reset_pb, e.exp); end
      e = sb.pop_front(); total++;
      if (32'(retry_cnt) !== e.exp) begin bad++; $display("FAIL %s: got %0h want %0h", e.name, retry_cnt, e.exp); end
      e = sb.pop_front(); total++;
      if (32'(link_fail) !== e.exp) begin bad++; $display("FAIL %s: got %0h want %0h", e.name, link_fail, e.exp); end
   endtask

   task automatic test_errors();
      int c;
      do_reset();
      channel_up = 1'b1; lane_up = 1'b1;
      c = 0;
      while (link_ready !== 1'b1 && c < 100) begin @(negedge clk); c++; end
      soft_err = 1'b1;
      sb.push_back('{"soft_count5", 32'd5});
      repeat (5) @(negedge clk);
      soft_err = 1'b0;
      e = sb.pop_front(); total++;
      if (32'(soft_err_cnt) !== e.exp) begin bad++; $display("FAIL %s: got %0h want %0h", e.name, soft_err_cnt, e.exp); end
      hard_err = 1'b1; soft_err = 1'b1;
      sb.push_back('{"hard_state", 32'd3});
      sb.push_back('{"hard_reset_pb", 32'd1});
      sb.push_back('{"hard_link_ready", 32'd0});
      sb.push_back('{"hard_soft_hold", 32'd5});
      sb.push_back('{"hard_retry", 32'd1});
      @(negedge clk);
      hard_err = 1'b0; soft_err = 1'b0;
      e = sb.pop_front(); total++;
      if (32'(state_o) !== e.exp) begin bad++; $display("FAIL %s: got %0h want %0h", e.name, state_o, e.exp); end
      e = sb.pop_front(); total++;
      if (32'(reset_pb) !== e.exp) begin bad++; $display("FAIL %s: got %0h want %0h", e.name, reset_pb, e.exp); end
      e = sb.pop_front(); total++;
      if (32'(link_ready) !== e.exp) begin bad++; $display("FAIL %s: got %0h want %0h", e.name, link_ready, e.exp); end
      e = sb.pop_front(); total++;
      if (32'(soft_err_cnt) !== e.exp) begin bad++; $display("FAIL %s: got %0h want %0h", e.name, soft_err_cnt, e.exp); end
      e = sb.pop_front(); total++;
      if (32'(retry_cnt) !== e.exp) begin bad++; $display("FAIL %s: got %0h want %0h", e.name, retry_cnt, e.exp); end
      sb.push_back('{"relink_retry", 32'd0});
      c = 0;
      while (link_ready !== 1'b1 && c < 100) begin @(negedge clk); c++; end
      e = sb.pop_front(); total++;
      if (32'(retry_cnt) !== e.exp) begin bad++; $display("FAIL %s: got %0h want %0h", e.name, retry_cnt, e.exp); end
      lane_up = 1'b0;
      sb.push_back('{"lane_drop_state", 32'd3});
      sb.push_back('{"lane_drop_retry", 32'd1});
      @(negedge clk);
      lane_up = 1'b1;
      e = sb.pop_front(); total++;
      if (32'(state_o) !== e.exp) begin bad++; $display("FAIL %s: got %0h want %0h", e.name, state_o, e.exp); end
      e = sb.pop_front(); total++;
      if (32'(retry_cnt) !== e.exp) begin bad++; $display("FAIL %s: got %0h want %0h", e.name, retry_cnt, e.exp); end
      retry_clr = 1'b1;
      sb.push_back('{"clr_keep_state", 32'd3});
      sb.push_back('{"clr_retry_zero", 32'd0});
      sb.push_back('{"clr_soft_zero", 32'd0});
      @(negedge clk);
      retry_clr = 1'b0;
      e = sb.pop_front(); total++;
      if (32'(state_o) !== e.exp) begin bad++; $display("FAIL %s: got %0h want %0h", e.name, state_o, e.exp); end
      e = sb.pop_front(); total++;
      if (32'(retry_cnt) !== e.exp) begin bad++; $display("FAIL %s: got %0h want %0h", e.name, retry_cnt, e.exp); end
      e = sb.pop_front(); total++;
      if (32'(soft_err_cnt) !== e.exp) begin bad++; $display("FAIL %s: got %0h want %0h", e.name, soft_err_cnt, e.exp); end
   endtask

   task automatic test_soft_saturate();
      int c;
      c = 0;
      while (link_ready !== 1'b1 && c < 100) begin @(negedge clk); c++; end
      sb.push_back('{"sat_start", 32'd0});
      sb.push_back('{"sat_edge_minus1", 32'h0000fffe});
      sb.push_back('{"sat_hold", 32'h0000ffff});
      sb.push_back('{"sat_link_ready", 32'd1});
      e = sb.pop_front(); total++;
      if (32'(soft_err_cnt) !== e.exp) begin bad++; $display("FAIL %s: got %0h want %0h", e.name, soft_err_cnt, e.exp); end
      soft_err = 1'b1;
      repeat (65534) @(negedge clk);
      e = sb.pop_front(); total++;
      if (32'(soft_err_cnt) !== e.exp) begin bad++; $display("FAIL %s: got %0h want %0h", e.name, soft_err_cnt, e.exp); end
      repeat (70000 - 65534) @(negedge clk);
      soft_err = 1'b0;
      e = sb.pop_front(); total++;
      if (32'(soft_err_cnt) !== e.exp) begin bad++; $display("FAIL %s: got %0h want %0h", e.name, soft_err_cnt, e.exp); end
      e = sb.pop_front(); total++;
      if (32'(link_ready) !== e.exp) begin bad++; $display("FAIL %s: got %0h want %0h", e.name, link_ready, e.exp); end
   endtask

   task automatic test_reset_mid_pulse();
      int c;
      do_reset();
      c = 0;
      while (reset_pb !== 1'b1 && c < 300) begin @(negedge clk); c++; end
      repeat (3) @(negedge clk);
      sb.push_back('{"mid_pulse_pb", 32'd1});
      sb.push_back('{"mid_pulse_retry", 32'd1});
      e = sb.pop_front(); total++;
      if (32'(reset_pb) !== e.exp) begin bad++; $display("FAIL %s: got %0h want %0h", e.name, reset_pb, e.exp); end
      e = sb.pop_front(); total++;
      if (32'(retry_cnt) !== e.exp) begin bad++; $display("FAIL %s: got %0h want %0h", e.name, retry_cnt, e.exp); end
      aurora_rst = 1'b1;
      sb.push_back('{"abort_pb", 32'd0});
      sb.push_back('{"abort_state", 32'd0});
      sb.push_back('{"abort_retry", 32'd0});
      sb.push_back('{"abort_soft", 32'd0});
      sb.push_back('{"abort_link_fail", 32'd0});
      sb.push_back('{"abort_no_resume", 32'd0});
      @(negedge clk);
      e = sb.pop_front(); total++;
      if (32'(reset_pb) !== e.exp) begin bad++; $display("FAIL %s: got %0h want %0h", e.name, reset_pb, e.exp); end
      e = sb.pop_front(); total++;
      if (32'(state_o) !== e.exp) begin bad++; $display("FAIL %s: got %0h want %0h", e.name, state_o, e.exp); end
      e = sb.pop_front(); total++;
      if (32'(retry_cnt) !== e.exp) begin bad++; $display("FAIL %s: got %0h want %0h", e.name, retry_cnt, e.exp); end
      e = sb.pop_front(); total++;
      if (32'(soft_err_cnt) !== e.exp) begin bad++; $display("FAIL %s: got %0h want %0h", e.name, soft_err_cnt, e.exp); end
      e = sb.pop_front(); total++;
      if (32'(link_fail) !== e.exp) begin bad++; $display("FAIL %s: got %0h want %0h", e.name, link_fail, e.exp); end
      aurora_rst = 1'b0;
      repeat (20) @(negedge clk);
      e = sb.pop_front(); total++;
      if (32'(reset_pb) !== e.exp) begin bad++; $display("FAIL %s: got %0h want %0h", e.name, reset_pb, e.exp); end
   endtask

   initial begin
      aurora_rst = 1'b1;
      channel_up = 1'b0; lane_up = 1'b0; hard_err = 1'b0; soft_err = 1'b0; retry_clr = 1'b0;
      test_reset();
      test_link_up();
      test_timeout();
      test_fail();
      test_errors();
      test_soft_saturate();
      test_reset_mid_pulse();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
